// File: rtl/dmem_resp_pkg.sv
// Shared widths, default memory geometry and the byte-lane merge used for write-first reads.
// Combinational helpers only; no latency, no flow control.
package dmem_resp_pkg;

    localparam int          DW            = 32;
    localparam int          SW            = DW / 8;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam int          DEF_DEPTH     = 4096;

    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_dat,
                                                  input logic [SW-1:0] sel,
                                                  input logic [DW-1:0] new_dat);
        logic [DW-1:0] res;
        res = old_dat;
        for (int n = 0; n < SW; n++) begin
            if (sel[n]) res[8*n +: 8] = new_dat[8*n +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Word RAM with byte-lane writes and one registered read port (write-first on same address).
// Read latency 1, write commits on the edge; always ready, read output holds between reads.
module dmem_ram_bank
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [SW-1:0] wr_sel_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_q;
    logic          byp_q;
    logic [SW-1:0] byp_sel_q;
    logic [DW-1:0] byp_dat_q;

    // The array read is read-first; a colliding write is captured beside it and overlaid on output.
    always_ff @(posedge clk) begin
        for (int n = 0; n < SW; n++) begin
            if (wr_en_i && wr_sel_i[n]) mem_q[wr_addr_i][8*n +: 8] <= wr_data_i[8*n +: 8];
        end
        if (rd_en_i) begin
            rd_q      <= mem_q[rd_addr_i];
            byp_q     <= wr_en_i && (wr_addr_i == rd_addr_i);
            byp_sel_q <= wr_sel_i;
            byp_dat_q <= wr_data_i;
        end
    end

    assign rd_data_o = byp_q ? merge_lanes(rd_q, byp_sel_q, byp_dat_q) : rd_q;

endmodule

// File: rtl/dmem_resp.sv
// CPU data-memory responder: range check, byte-lane writes, write-first reads, error capture.
// Reads return one cycle after the request, writes commit on the edge; no back-pressure.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = DEF_DEPTH,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_rd_req_i,
    input  logic [31:0]   mem_rd_addr_i,
    output logic [DW-1:0] mem_rd_data_o,
    input  logic          mem_wr_req_i,
    input  logic [SW-1:0] mem_wr_sel_i,
    input  logic [31:0]   mem_wr_addr_i,
    input  logic [DW-1:0] mem_wr_data_i,
    output logic          err_o,
    output logic [31:0]   err_addr_o,
    output logic [15:0]   err_cnt_o
);

    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    logic [31:0]   rd_off, wr_off;
    logic          rd_in, wr_in, rd_err, wr_err;
    logic          ram_rd_en, ram_wr_en;
    logic [DW-1:0] ram_rd_dat;

    logic          rd_zero_q, rd_zero_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    assign rd_off = mem_rd_addr_i - BASE_ADDR;
    assign wr_off = mem_wr_addr_i - BASE_ADDR;
    assign rd_in  = {1'b0, rd_off} < SPAN;
    assign wr_in  = {1'b0, wr_off} < SPAN;
    assign rd_err = mem_rd_req_i && !rd_in;
    assign wr_err = mem_wr_req_i && !wr_in && (mem_wr_sel_i != '0);

    // The RAM has no reset, so the asynchronous reset must also block commits directly.
    assign ram_wr_en = mem_wr_req_i && wr_in && rst;
    assign ram_rd_en = mem_rd_req_i && rd_in && rst;

    dmem_ram_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_sel_i  (mem_wr_sel_i),
        .wr_addr_i (wr_off[AW+1:2]),
        .wr_data_i (mem_wr_data_i),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (rd_off[AW+1:2]),
        .rd_data_o (ram_rd_dat)
    );

    always_comb begin
        rd_zero_d  = rd_zero_q;
        err_d      = rd_err || wr_err;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (mem_rd_req_i) rd_zero_d = !rd_in;
        if (err_d) begin
            err_addr_d = wr_err ? mem_wr_addr_i : mem_rd_addr_i;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_zero_q  <= 1'b1;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            rd_zero_q  <= rd_zero_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Stale RAM output is masked after reset or an out-of-range read.
    assign mem_rd_data_o = rd_zero_q ? '0 : ram_rd_dat;
    assign err_o         = err_q;
    assign err_addr_o    = err_addr_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
